// File: rtl/sdram_mp_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sdram_mp_arbiter: round-robin Avalon-MM front end for the SDRAM controller, with read-tag FIFO.
// Optional build macro SDRAM_ARB_PRIO0_EN gives channel 0 fixed priority. Rev 1.0
// ----------------------------------------------------------------------------
module sdram_mp_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 25,
  parameter int MAX_PEND = 4,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_chipselect,
  input  logic [NUM_CH-1:0]        ch_read_n,
  input  logic [NUM_CH-1:0]        ch_write_n,
  input  logic [NUM_CH*BE_W-1:0]   ch_byteenable_n,
  input  logic [NUM_CH*ADDR_W-1:0] ch_address,
  input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
  output logic [NUM_CH*DATA_W-1:0] ch_read_data,
  output logic [NUM_CH-1:0]        ch_wait_request,
  output logic [NUM_CH-1:0]        ch_data_validation,
  output logic                     az_cs,
  output logic                     az_rd_n,
  output logic                     az_wr_n,
  output logic [ADDR_W-1:0]        az_addr,
  output logic [BE_W-1:0]          az_be_n,
  output logic [DATA_W-1:0]        az_data,
  input  logic [DATA_W-1:0]        za_data,
  input  logic                     za_valid,
  input  logic                     za_waitrequest,
  output logic                     err_orphan
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t            state_q;
  logic [CH_W-1:0]   grant_q, rr_q, grant_d;
  logic [CH_W-1:0]   tag_q [MAX_PEND];
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata_q [NUM_CH];
  logic [NUM_CH-1:0] dval_q;
  logic              err_q;

  logic [ADDR_W-1:0] addr_a  [NUM_CH];
  logic [BE_W-1:0]   be_a    [NUM_CH];
  logic [DATA_W-1:0] wdata_a [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic              full, found, in_issue, sel_rd, sel_wr, accept, push, pop;
  int                idx;

  assign full     = (cnt_q == CNT_W'(MAX_PEND));
  assign in_issue = (state_q == ISSUE);
  // Both strobes low counts as a write, so a read needs write_n high.
  assign sel_wr   = ~ch_write_n[grant_q];
  assign sel_rd   = ~ch_read_n[grant_q] & ch_write_n[grant_q];
  assign accept   = in_issue & ~za_waitrequest;
  assign push     = accept & sel_rd;
  assign pop      = za_valid & (cnt_q != '0);

  always_comb begin : unpack
    for (int i = 0; i < NUM_CH; i++) begin
      addr_a[i]  = ch_address[i*ADDR_W +: ADDR_W];
      be_a[i]    = ch_byteenable_n[i*BE_W +: BE_W];
      wdata_a[i] = ch_write_data[i*DATA_W +: DATA_W];
      elig[i]    = ch_chipselect[i] & (~ch_write_n[i] | (~ch_read_n[i] & ~full));
    end
  end

  always_comb begin : arbitrate
    found   = 1'b0;
    grant_d = '0;
    idx     = 0;
`ifdef SDRAM_ARB_PRIO0_EN
    if (elig[0]) found = 1'b1;
`endif
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(rr_q) + k) % NUM_CH;
`ifdef SDRAM_ARB_PRIO0_EN
      if (!found && idx != 0 && elig[idx]) begin
`else
      if (!found && elig[idx]) begin
`endif
        found   = 1'b1;
        grant_d = CH_W'(idx);
      end
    end
  end

  always_comb begin : drive
    az_cs   = in_issue;
    az_rd_n = ~(in_issue & sel_rd);
    az_wr_n = ~(in_issue & sel_wr);
    az_addr = in_issue ? addr_a[grant_q]  : '0;
    az_be_n = in_issue ? be_a[grant_q]    : '0;
    az_data = in_issue ? wdata_a[grant_q] : '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wait_request[i]                = ~(accept && (grant_q == CH_W'(i)));
      ch_read_data[i*DATA_W +: DATA_W]  = rdata_q[i];
    end
  end

  assign ch_data_validation = dval_q;
  assign err_orphan         = err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      dval_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < MAX_PEND; i++) tag_q[i] <= '0;
      for (int i = 0; i < NUM_CH; i++) rdata_q[i] <= '0;
    end else begin
      dval_q <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= grant_d;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (accept) begin
            state_q <= IDLE;
`ifdef SDRAM_ARB_PRIO0_EN
            if (grant_q != '0) rr_q <= grant_q;
`else
            rr_q <= grant_q;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
      if (push) begin
        tag_q[wptr_q] <= grant_q;
        wptr_q        <= wptr_q + PTR_W'(1);
      end
      // Responses return in issue order, so the FIFO head owns every beat.
      if (pop) begin
        rdata_q[tag_q[rptr_q]] <= za_data;
        dval_q[tag_q[rptr_q]]  <= 1'b1;
        rptr_q                 <= rptr_q + PTR_W'(1);
      end else if (za_valid) begin
        err_q <= 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire
